// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, status codes,
// ALU/condition function codes, and the M pipeline-register layout with its bubble value.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fn_t;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } mreg_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam mreg_t M_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0, val_e: 64'd0,
                                   val_a: 64'd0, dst_e: REG_NONE, dst_m: REG_NONE};

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Any exception status downstream freezes the condition codes.
    function automatic logic stat_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/execute_if.sv
// Execute-stage bundle: E register fields in, forwarded results, M register and CC out.
// master = decode/pipeline side driving E fields, slave = execute stage.
interface execute_if;
    logic [2:0]         E_stat;
    logic [3:0]         E_icode;
    logic [3:0]         E_ifun;
    logic signed [63:0] E_valC;
    logic signed [63:0] E_valA;
    logic signed [63:0] E_valB;
    logic [3:0]         E_dstE;
    logic [3:0]         E_dstM;
    logic [2:0]         m_stat;
    logic [2:0]         W_stat;
    logic               M_bubble;

    logic signed [63:0] e_valE;
    logic [3:0]         e_dstE;
    logic               e_Cnd;

    logic [2:0]         M_stat;
    logic [3:0]         M_icode;
    logic               M_Cnd;
    logic signed [63:0] M_valE;
    logic signed [63:0] M_valA;
    logic [3:0]         M_dstE;
    logic [3:0]         M_dstM;

    logic               cc_zf;
    logic               cc_sf;
    logic               cc_of;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               m_stat, W_stat, M_bubble,
        input  e_valE, e_dstE, e_Cnd,
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
               cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               m_stat, W_stat, M_bubble,
        output e_valE, e_dstE, e_Cnd,
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
               cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/alu64.sv
// 64-bit combinational ALU (add/sub/and/xor) with zero/sign/overflow flags.
// Latency: zero cycles; no flow control.
module alu64
    import y86_pkg::*;
(
    input  logic [3:0]         fn,
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    output logic signed [63:0] r,
    output logic               zf,
    output logic               sf,
    output logic               of
);

    always_comb begin
        r  = '0;
        of = 1'b0;
        case (fn)
            ALU_ADD: begin
                r  = b + a;
                of = (a[63] == b[63]) && (r[63] != a[63]);
            end
            ALU_SUB: begin
                r  = b - a;
                of = (a[63] != b[63]) && (r[63] != b[63]);
            end
            ALU_AND: r = b & a;
            ALU_XOR: r = b ^ a;
            default: r = '0;
        endcase
    end

    assign zf = (r == 64'sd0);
    assign sf = r[63];

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: operand select, ALU, CC register, branch/cmov condition, M register.
// Latency: e_* combinational, M register one cycle; no backpressure, M_bubble squashes the M load.
module execute
    import y86_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    execute_if.slave ex
);

    logic signed [63:0] alu_a;
    logic signed [63:0] alu_b;
    logic signed [63:0] alu_r;
    logic [3:0]         alu_fn;
    cc_t                alu_cc;
    cc_t                cc_q;
    mreg_t              m_q;
    logic               set_cc;
    logic               cond;
    logic               cnd;
    logic [3:0]         dst_e;

    always_comb begin
        alu_a = '0;
        case (ex.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = ex.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.E_valC;
            I_CALL, I_PUSHQ:              alu_a = -64'sd8;
            I_RET, I_POPQ:                alu_a = 64'sd8;
            default:                      alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = ex.E_valB;
            default: alu_b = '0;
        endcase
    end

    assign alu_fn = (ex.E_icode == I_OPQ) ? ex.E_ifun : ALU_ADD;

    alu64 u_alu (
        .fn (alu_fn),
        .a  (alu_a),
        .b  (alu_b),
        .r  (alu_r),
        .zf (alu_cc.zf),
        .sf (alu_cc.sf),
        .of (alu_cc.of)
    );

    assign set_cc = (ex.E_icode == I_OPQ) && (ex.E_ifun <= ALU_XOR)
                 && !stat_exc(ex.m_stat) && !stat_exc(ex.W_stat);

    // Condition uses the CC as registered before this edge, so an OPq result
    // becomes visible to the very next instruction without a stall.
    always_comb begin
        cond = 1'b0;
        case (ex.E_ifun)
            C_YES:   cond = 1'b1;
            C_LE:    cond = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            C_L:     cond = cc_q.sf ^ cc_q.of;
            C_E:     cond = cc_q.zf;
            C_NE:    cond = !cc_q.zf;
            C_GE:    cond = !(cc_q.sf ^ cc_q.of);
            C_G:     cond = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd   = ((ex.E_icode == I_RRMOVQ) || (ex.E_icode == I_JXX)) ? cond : 1'b0;
    assign dst_e = ((ex.E_icode == I_RRMOVQ) && !cnd) ? REG_NONE : ex.E_dstE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= CC_RESET;
            m_q  <= M_BUBBLE;
        end else begin
            if (set_cc) begin
                cc_q <= alu_cc;
            end
            if (ex.M_bubble) begin
                m_q <= M_BUBBLE;
            end else begin
                m_q <= '{stat: ex.E_stat, icode: ex.E_icode, cnd: cnd, val_e: alu_r,
                         val_a: ex.E_valA, dst_e: dst_e, dst_m: ex.E_dstM};
            end
        end
    end

    assign ex.e_valE  = alu_r;
    assign ex.e_dstE  = dst_e;
    assign ex.e_Cnd   = cnd;

    assign ex.M_stat  = m_q.stat;
    assign ex.M_icode = m_q.icode;
    assign ex.M_Cnd   = m_q.cnd;
    assign ex.M_valE  = m_q.val_e;
    assign ex.M_valA  = m_q.val_a;
    assign ex.M_dstE  = m_q.dst_e;
    assign ex.M_dstM  = m_q.dst_m;

    assign ex.cc_zf   = cc_q.zf;
    assign ex.cc_sf   = cc_q.sf;
    assign ex.cc_of   = cc_q.of;

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed scenarios then randomized instructions against an arithmetic reference model.
module tb_execute;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_if bus ();

    execute dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    typedef struct packed {
        logic        rst;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] c;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [2:0]  ms;
        logic [2:0]  ws;
        logic        bub;
    } step_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } mexp_t;

    localparam mexp_t BUB = '{stat: 3'd1, icode: 4'h1, cnd: 1'b0, vale: 64'd0,
                              vala: 64'd0, dste: 4'hF, dstm: 4'hF};

    int    checks = 0;
    int    errors = 0;
    logic  mzf, msf, mof;
    mexp_t em;
    logic [63:0] obs_vale;
    logic        obs_cnd;
    logic [3:0]  obs_dste;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic: overflow judged by whether the exact sum fits in 64 signed bits.
    function automatic logic [63:0] ref_op(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                                           output logic fz, output logic fs, output logic fo);
        logic signed [65:0] exact;
        logic signed [65:0] smax;
        logic signed [65:0] smin;
        logic [63:0] r;
        smax  = (66'sd1 <<< 63) - 66'sd1;
        smin  = -(66'sd1 <<< 63);
        fo    = 1'b0;
        exact = '0;
        case (fn)
            4'd0: begin exact = {{2{b[63]}}, b} + {{2{a[63]}}, a}; r = b + a; fo = (exact > smax) || (exact < smin); end
            4'd1: begin exact = {{2{b[63]}}, b} - {{2{a[63]}}, a}; r = b - a; fo = (exact > smax) || (exact < smin); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            default: r = 64'd0;
        endcase
        fz = (r == 64'd0);
        fs = r[63];
        return r;
    endfunction

    function automatic logic [63:0] ref_vale(input step_t s, output logic fz, output logic fs, output logic fo);
        fz = 1'b0; fs = 1'b0; fo = 1'b0;
        case (s.icode)
            4'h2:       return s.a;
            4'h3:       return s.c;
            4'h4, 4'h5: return s.b + s.c;
            4'h6:       return ref_op(s.ifun, s.a, s.b, fz, fs, fo);
            4'h8, 4'hA: return s.b - 64'd8;
            4'h9, 4'hB: return s.b + 64'd8;
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
        logic lt;
        lt = (sf != of);
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt || zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic step_t op(input logic [3:0] icode, input logic [3:0] ifun,
                                 input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] dste);
        return '{rst: 1'b1, stat: 3'd1, icode: icode, ifun: ifun, c: c, a: a, b: b,
                 dste: dste, dstm: 4'hF, ms: 3'd1, ws: 3'd1, bub: 1'b0};
    endfunction

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input step_t s);
        logic [63:0] xv;
        logic fz, fs, fo, xc;
        logic [3:0] xd;
        rst_n        = s.rst;
        bus.E_stat   = s.stat;
        bus.E_icode  = s.icode;
        bus.E_ifun   = s.ifun;
        bus.E_valC   = s.c;
        bus.E_valA   = s.a;
        bus.E_valB   = s.b;
        bus.E_dstE   = s.dste;
        bus.E_dstM   = s.dstm;
        bus.m_stat   = s.ms;
        bus.W_stat   = s.ws;
        bus.M_bubble = s.bub;
        #1;
        xv = ref_vale(s, fz, fs, fo);
        xc = (s.icode == 4'h2 || s.icode == 4'h7) ? ref_cond(s.ifun, mzf, msf, mof) : 1'b0;
        xd = (s.icode == 4'h2 && !xc) ? 4'hF : s.dste;
        obs_vale = bus.e_valE;
        obs_cnd  = bus.e_Cnd;
        obs_dste = bus.e_dstE;
        check("e_valE", obs_vale, xv);
        check("e_Cnd", obs_cnd, xc);
        check("e_dstE", obs_dste, xd);
        @(posedge clk);
        if (!s.rst) begin
            {mzf, msf, mof} = 3'b100;
            em = BUB;
        end else begin
            if (s.icode == 4'h6 && s.ifun < 4'd4 && !(s.ms >= 3'd2 && s.ms <= 3'd4)
                && !(s.ws >= 3'd2 && s.ws <= 3'd4))
                {mzf, msf, mof} = {fz, fs, fo};
            em = s.bub ? BUB : '{stat: s.stat, icode: s.icode, cnd: xc, vale: xv,
                                 vala: s.a, dste: xd, dstm: s.dstm};
        end
        @(negedge clk);
        check("M_stat", bus.M_stat, em.stat);
        check("M_icode", bus.M_icode, em.icode);
        check("M_Cnd", bus.M_Cnd, em.cnd);
        check("M_valE", bus.M_valE, em.vale);
        check("M_valA", bus.M_valA, em.vala);
        check("M_dstE", bus.M_dstE, em.dste);
        check("M_dstM", bus.M_dstM, em.dstm);
        check("cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, {mzf, msf, mof});
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 4))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 16));
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return 64'($signed(-$urandom_range(1, 16)));
        endcase
    endfunction

    initial begin
        step_t s;
        rst_n = 1'b0;
        s = op(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        bus.E_stat = 3'd1; bus.E_icode = 4'h1; bus.E_ifun = 4'h0;
        bus.E_valC = '0; bus.E_valA = '0; bus.E_valB = '0;
        bus.E_dstE = 4'hF; bus.E_dstM = 4'hF;
        bus.m_stat = 3'd1; bus.W_stat = 3'd1; bus.M_bubble = 1'b0;
        @(posedge clk);
        @(negedge clk);
        {mzf, msf, mof} = 3'b100;
        em = BUB;

        // Reset state held with a bubble request and an instruction in E
        s.rst = 1'b0; s.bub = 1'b1;
        cycle(s);
        check("rst_cc_zf", bus.cc_zf, 1'b1);
        check("rst_M_icode", bus.M_icode, 4'h1);

        // OPq sub 5-5 then je
        cycle(op(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h3));
        check("sub_valE", obs_vale, 64'd0);
        check("sub_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
        cycle(op(4'h7, 4'h3, 64'h100, 64'd0, 64'd0, 4'hF));
        check("je_cnd", obs_cnd, 1'b1);

        // Signed overflow on add
        cycle(op(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2));
        check("ovf_valE", obs_vale, 64'hFFFF_FFFF_FFFF_FFFE);
        check("ovf_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b011);

        // Clear CC, then cmovle not taken
        cycle(op(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2));
        check("clr_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b000);
        cycle(op(4'h2, 4'h1, 64'd0, 64'd77, 64'd0, 4'h3));
        check("cmovle_cnd", obs_cnd, 1'b0);
        check("cmovle_dstE", obs_dste, 4'hF);
        check("cmovle_M_dstE", bus.M_dstE, 4'hF);

        // Stack pointer arithmetic leaves CC alone
        cycle(op(4'hA, 4'h0, 64'd0, 64'd0, 64'd1023, 4'h4));
        check("push_valE", obs_vale, 64'd1015);
        cycle(op(4'hB, 4'h0, 64'd0, 64'd0, 64'd1023, 4'h4));
        check("pop_valE", obs_vale, 64'd1031);
        check("stack_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b000);

        // xor with ADR in memory and bubble: CC frozen, M squashed
        s = op(4'h6, 4'h3, 64'd0, 64'd5, 64'd5, 4'h1);
        s.ms = 3'd3; s.bub = 1'b1;
        cycle(s);
        check("adr_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b000);
        check("adr_M_icode", bus.M_icode, 4'h1);
        check("adr_M_dstE", bus.M_dstE, 4'hF);

        // Bubble alone does not block the CC update
        s.ms = 3'd1;
        cycle(s);
        check("bub_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);

        // Clear CC, then reset mid-stream during an overflowing add
        cycle(op(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2));
        s = op(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2);
        s.rst = 1'b0;
        cycle(s);
        check("mid_rst_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
        check("mid_rst_M_stat", bus.M_stat, 3'd1);
        check("mid_rst_M_valE", bus.M_valE, 64'd0);

        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 29) != 0);
            s.stat  = 3'($urandom_range(0, 7));
            s.icode = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            s.ifun  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            s.c     = rand_val();
            s.a     = rand_val();
            s.b     = rand_val();
            s.dste  = 4'($urandom_range(0, 15));
            s.dstm  = 4'($urandom_range(0, 15));
            s.ms    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            s.ws    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            s.bub   = ($urandom_range(0, 7) == 0);
            cycle(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
